// File: rtl/sync_nd_filt_c.sv
// Purpose : bank of WIDTH level synchronizers with a per-channel stability filter,
//           rise/fall event pulses and sticky change flags.
// Latency : STAGES+FILT-1 edges after the edge that first samples a stable i_d.
//           All outputs are registered, with no combinational path from any input.
// Backpressure: none. The block is free-running, and i_d is sampled on every edge.
//
// Ports:
//   i_clk          core clock (rising edge)
//   i_clr          synchronous active-high reset; has priority over everything
//   i_d            asynchronous level inputs, one per channel
//   i_sticky_clr   per-bit clear of o_chg_sticky
//   o_q            synchronized, filtered level
//   o_rise/o_fall  one-cycle pulses in the first cycle o_q shows its new value
//   o_chg_sticky   set on any o_q change, held until cleared
module sync_nd_filt_c #(
    parameter int                 WIDTH   = 8,
    parameter int                 STAGES  = 3,
    parameter int                 FILT    = 4,
    parameter logic [WIDTH-1:0]   RST_VAL = '0,
    parameter int                 CNT_W   = $clog2(FILT + 1)
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_d,
    input  logic [WIDTH-1:0] i_sticky_clr,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall,
    output logic [WIDTH-1:0] o_chg_sticky
);

    // Fail elaboration on parameter values that cannot work.
    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("sync_nd_filt_c: STAGES must be >= 2");
        end
        if (FILT < 1) begin : g_bad_filt
            $error("sync_nd_filt_c: FILT must be >= 1");
        end
        if (WIDTH < 1) begin : g_bad_width
            $error("sync_nd_filt_c: WIDTH must be >= 1");
        end
    endgenerate

    // The terminal count is the last cycle of a run that is still too short.
    // A mismatch seen while the count equals this value completes the run.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT - 1);

    // Synchronizer chain. No logic is placed between the stages.
    logic [WIDTH-1:0] r_sync [STAGES];

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic [WIDTH-1:0] r_sticky;
    logic [CNT_W-1:0] r_cnt [WIDTH];

    logic [WIDTH-1:0] w_s_out;
    logic [WIDTH-1:0] w_upd;

    assign w_s_out = r_sync[STAGES-1];

    // An update fires when the synchronized level has differed from q for FILT
    // consecutive edges. With FILT=1, CNT_MAX is 0, so any difference updates at once.
    always_comb begin
        w_upd = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_upd[i] = (w_s_out[i] != r_q[i]) && (r_cnt[i] == CNT_MAX);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            for (int k = 0; k < STAGES; k++) begin
                r_sync[k] <= RST_VAL;
            end
        end else begin
            r_sync[0] <= i_d;
            for (int k = 1; k < STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_q      <= RST_VAL;
            r_rise   <= '0;
            r_fall   <= '0;
            r_sticky <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (w_s_out[i] == r_q[i]) begin
                    // Back at the filtered level: any partial run is discarded.
                    r_cnt[i] <= '0;
                end else if (w_upd[i]) begin
                    r_q[i]   <= w_s_out[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
            r_rise   <= w_upd & w_s_out;
            r_fall   <= w_upd & ~w_s_out;
            // A set on the same edge as a clear wins, so no change can be lost.
            r_sticky <= (r_sticky & ~i_sticky_clr) | w_upd;
        end
    end

    assign o_q          = r_q;
    assign o_rise       = r_rise;
    assign o_fall       = r_fall;
    assign o_chg_sticky = r_sticky;

endmodule

// File: tb/tb_sync_nd_filt_c.sv
// Purpose : directed checks of sync_nd_filt_c in its default configuration, plus a
//           corner-parameter instance checked against a delay-line reference.
// Latency : inputs are driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_sync_nd_filt_c;

    logic       clk;
    logic       clr_a, clr_b;
    logic [7:0] d_a, d_b, sc_a, sc_b;
    logic [7:0] q_a, rise_a, fall_a, st_a;
    logic [7:0] q_b, rise_b, fall_b, st_b;

    int n_tests = 0;
    int n_fail  = 0;

    sync_nd_filt_c #(.WIDTH(8), .STAGES(3), .FILT(4), .RST_VAL(8'h00)) u_dut_a (
        .i_clk        (clk),
        .i_clr        (clr_a),
        .i_d          (d_a),
        .i_sticky_clr (sc_a),
        .o_q          (q_a),
        .o_rise       (rise_a),
        .o_fall       (fall_a),
        .o_chg_sticky (st_a)
    );

    sync_nd_filt_c #(.WIDTH(8), .STAGES(2), .FILT(1), .RST_VAL(8'hA5)) u_dut_b (
        .i_clk        (clk),
        .i_clr        (clr_b),
        .i_d          (d_b),
        .i_sticky_clr (sc_b),
        .o_q          (q_b),
        .o_rise       (rise_b),
        .o_fall       (fall_b),
        .o_chg_sticky (st_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [7:0] acc_rise;
    logic [7:0] dh1, dh2, m_q, m_qp, m_st;

    initial begin
        clr_a = 1'b1; d_a = 8'hFF; sc_a = 8'h00;
        clr_b = 1'b1; d_b = 8'h00; sc_b = 8'h00;

        // 1: reset for two cycles with all inputs high
        for (int c = 0; c < 2; c++) begin
            tick();
            check("rst_q",    q_a,    8'h00);
            check("rst_rise", rise_a, 8'h00);
            check("rst_fall", fall_a, 8'h00);
            check("rst_st",   st_a,   8'h00);
            check("rst_qb",   q_b,    8'hA5);
        end
        clr_a = 1'b0;
        tick();
        check("rel_q",    q_a,    8'h00);
        check("rel_rise", rise_a, 8'h00);
        check("rel_fall", fall_a, 8'h00);
        check("rel_st",   st_a,   8'h00);
        // The single sampled FF is a one-cycle run and must be filtered out.
        d_a = 8'h00;
        repeat (10) tick();
        check("quiet_q",  q_a,  8'h00);
        check("quiet_st", st_a, 8'h00);

        // 2: step on d[0]. q updates at E0+6.
        d_a = 8'h01;
        repeat (6) tick();
        check("step_pre_q", q_a, 8'h00);
        tick();
        check("step_q",    q_a,    8'h01);
        check("step_rise", rise_a, 8'h01);
        check("step_fall", fall_a, 8'h00);
        check("step_st",   st_a,   8'h01);
        tick();
        check("step_rise_end", rise_a, 8'h00);
        check("step_q_hold",   q_a,    8'h01);

        // 3a: a 3-cycle glitch on d[1] is rejected.
        d_a = 8'h03;
        repeat (3) tick();
        d_a = 8'h01;
        acc_rise = 8'h00;
        repeat (10) begin
            tick();
            acc_rise |= rise_a;
        end
        check("glitch3_q",    q_a,      8'h01);
        check("glitch3_rise", acc_rise, 8'h00);
        check("glitch3_st",   st_a,     8'h01);

        // 3b: a 4-cycle pulse passes, with the fall 4 cycles after the rise.
        d_a = 8'h03;
        repeat (4) tick();
        d_a = 8'h01;
        repeat (2) tick();
        check("pulse4_pre_q", q_a, 8'h01);
        tick();
        check("pulse4_q",    q_a,    8'h03);
        check("pulse4_rise", rise_a, 8'h02);
        tick();
        check("pulse4_rise_end", rise_a, 8'h00);
        repeat (2) tick();
        check("pulse4_hold_q", q_a,    8'h03);
        check("pulse4_nofall", fall_a, 8'h00);
        tick();
        check("pulse4_fall_q", q_a,    8'h01);
        check("pulse4_fall",   fall_a, 8'h02);
        check("pulse4_st",     st_a,   8'h03);

        // 4: a clear on the same edge as a fall update loses to the set.
        d_a = 8'h00;
        repeat (6) tick();
        sc_a = 8'h01;
        tick();
        sc_a = 8'h00;
        check("stk_fall",  fall_a, 8'h01);
        check("stk_setwin", st_a,  8'h03);
        sc_a = 8'h01;
        tick();
        sc_a = 8'h00;
        check("stk_clr0", st_a, 8'h02);
        sc_a = 8'h02;
        tick();
        sc_a = 8'h00;
        check("stk_clr1", st_a, 8'h00);

        // 5: reset at E0+4 discards a filter run in progress.
        d_a = 8'h04;
        repeat (4) tick();
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        check("midrst_q",    q_a,    8'h00);
        check("midrst_rise", rise_a, 8'h00);
        repeat (6) tick();
        check("midrst_pre_q", q_a, 8'h00);
        tick();
        check("midrst_q_up",  q_a,    8'h04);
        check("midrst_rise1", rise_a, 8'h04);

        // 6: corner parameters STAGES=2, FILT=1, RST_VAL=A5
        d_b = 8'h5A;
        tick();
        check("b_rst_q",    q_b,    8'hA5);
        check("b_rst_rise", rise_b, 8'h00);
        clr_b = 1'b0;
        repeat (2) tick();
        check("b_pre_q", q_b, 8'hA5);
        tick();
        check("b_q",    q_b,    8'h5A);
        check("b_rise", rise_b, 8'h5A);
        check("b_fall", fall_b, 8'hA5);
        check("b_st",   st_b,   8'hFF);
        tick();
        check("b_rise_end", rise_b, 8'h00);
        check("b_fall_end", fall_b, 8'h00);

        // Random toggling against a delay line: q after edge n equals d sampled at n-2.
        dh1 = 8'h5A; dh2 = 8'h5A; m_q = 8'h5A; m_st = 8'hFF;
        for (int n = 0; n < 40; n++) begin
            d_b  = 8'($urandom);
            sc_b = 8'($urandom);
            tick();
            m_qp = m_q;
            m_q  = dh2;
            dh2  = dh1;
            dh1  = d_b;
            m_st = (m_st & ~sc_b) | (m_q ^ m_qp);
            check("rnd_q",    q_b,    m_q);
            check("rnd_rise", rise_b, m_q & ~m_qp);
            check("rnd_fall", fall_b, ~m_q & m_qp);
            check("rnd_st",   st_b,   m_st);
        end
        sc_b = 8'h00;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
